// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a four-state sender
// that hands one byte at a time to the transmitter using a TX_EN / TX_DONE handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          SCLK,
  input  logic          SCLR,
  input  logic          WR_EN,
  input  logic [7:0]    WR_DATA,
  input  logic          FLUSH,
  input  logic          CLR_OVR,
  input  logic          TX_DONE,
  output logic          TX_EN,
  output logic [7:0]    TX_DATA,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          BUSY,
  output logic          OVERRUN
);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_LOW} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    txd_q, txd_d;
  logic          done_q;
  logic          pop, wr_ok, done_rise;

  // A pop frees a slot in the same cycle, so a write while full is still taken.
  assign pop       = (state_q == LOAD) && !FLUSH;
  assign wr_ok     = WR_EN && !FLUSH && (!full_q || pop);
  assign done_rise = TX_DONE && !done_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    txd_d   = txd_q;
    if (CLR_OVR) ovr_d = 1'b0;
    if (WR_EN && !FLUSH && full_q && !pop) ovr_d = 1'b1;
    if (FLUSH) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
        txd_d  = mem_q[rptr_q];
      end
      count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d = state_q;
    TX_EN   = 1'b0;
    BUSY    = 1'b0;
    unique case (state_q)
      IDLE:     if (!empty_q && !FLUSH) state_d = LOAD;
      LOAD:     state_d = FLUSH ? IDLE : REQ;
      REQ: begin
        TX_EN = 1'b1;
        BUSY  = 1'b1;
        if (done_rise) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        BUSY = 1'b1;
        if (!TX_DONE) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovr_q   <= 1'b0;
      txd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovr_q   <= ovr_d;
      txd_q   <= txd_d;
      done_q  <= TX_DONE;
    end
  end

  // Buffer contents survive reset; only the pointers define what is valid.
  always_ff @(posedge SCLK) begin
    if (wr_ok) mem_q[wptr_q] <= WR_DATA;
  end

  assign TX_DATA = txd_q;
  assign FULL    = full_q;
  assign EMPTY   = empty_q;
  assign COUNT   = count_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table for the basic
// three-byte handshake plus hand sequences for latency, overflow, reset and flush.
module tb_uart_tx_fifo;

  logic       SCLK, SCLR, WR_EN, FLUSH, CLR_OVR, TX_DONE;
  logic [7:0] WR_DATA;
  logic       TX_EN, FULL, EMPTY, BUSY, OVERRUN;
  logic [7:0] TX_DATA;
  logic [4:0] COUNT;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .SCLK(SCLK), .SCLR(SCLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FLUSH(FLUSH),
    .CLR_OVR(CLR_OVR), .TX_DONE(TX_DONE), .TX_EN(TX_EN), .TX_DATA(TX_DATA),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic [17:0] exp;
  } vec_t;

  vec_t vt[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [17:0] pk(logic en, logic [7:0] d, logic f, logic e,
                                     logic [4:0] c, logic b, logic o);
    return {en, d, f, e, c, b, o};
  endfunction

  function automatic void add(logic wr, logic [7:0] d, logic done, logic [17:0] exp);
    vec_t v;
    v.wr = wr; v.d = d; v.done = done; v.exp = exp;
    vt.push_back(v);
  endfunction

  function automatic logic [17:0] obs();
    return {TX_EN, TX_DATA, FULL, EMPTY, COUNT, BUSY, OVERRUN};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_reset();
    WR_EN = 0; WR_DATA = 0; FLUSH = 0; CLR_OVR = 0; TX_DONE = 0;
    SCLR = 1;
    #2;
    chk("reset state", 32'(obs()), 32'(pk(0, 8'h00, 0, 1, 0, 0, 0)));
    SCLR = 0;
  endtask

  task automatic write1(logic [7:0] d);
    WR_EN = 1; WR_DATA = d;
    tick();
    WR_EN = 0;
  endtask

  task automatic wait_en(string nm);
    for (int k = 0; k < 10 && !TX_EN; k++) tick();
    chk({nm, " tx_en arrives"}, 32'(TX_EN), 32'd1);
  endtask

  task automatic finish_frame();
    TX_DONE = 1; tick();
    TX_DONE = 0; tick();
  endtask

  initial begin
    logic seen;
    logic [7:0] e;
    SCLR = 1;
    do_reset();

    // Three bytes, TX_DONE high 4 cycles per frame.
    add(1, 8'h01, 0, pk(0, 8'h00, 0, 0, 1, 0, 0));
    add(1, 8'h02, 0, pk(0, 8'h00, 0, 0, 2, 0, 0));
    add(1, 8'h03, 0, pk(1, 8'h01, 0, 0, 2, 1, 0));
    add(0, 8'h00, 0, pk(1, 8'h01, 0, 0, 2, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 8'h00, 1, pk(0, 8'h01, 0, 0, 2, 1, 0));
    add(0, 8'h00, 0, pk(0, 8'h01, 0, 0, 2, 0, 0));
    add(0, 8'h00, 0, pk(0, 8'h01, 0, 0, 2, 0, 0));
    add(0, 8'h00, 0, pk(1, 8'h02, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 8'h00, 1, pk(0, 8'h02, 0, 0, 1, 1, 0));
    add(0, 8'h00, 0, pk(0, 8'h02, 0, 0, 1, 0, 0));
    add(0, 8'h00, 0, pk(0, 8'h02, 0, 0, 1, 0, 0));
    add(0, 8'h00, 0, pk(1, 8'h03, 0, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 8'h00, 1, pk(0, 8'h03, 0, 1, 0, 1, 0));
    add(0, 8'h00, 0, pk(0, 8'h03, 0, 1, 0, 0, 0));
    add(0, 8'h00, 0, pk(0, 8'h03, 0, 1, 0, 0, 0));
    foreach (vt[i]) begin
      WR_EN = vt[i].wr; WR_DATA = vt[i].d; TX_DONE = vt[i].done;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].exp));
    end
    WR_EN = 0; TX_DONE = 0;

    // Single byte: exact 3-edge latency, first write right after reset.
    do_reset();
    write1(8'hA5);
    chk("first write count", 32'(COUNT), 32'd1);
    tick();
    chk("no tx_en at edge 2", 32'(TX_EN), 32'd0);
    tick();
    chk("A5 at edge 3", 32'({TX_EN, TX_DATA, BUSY, EMPTY}), 32'({1'b1, 8'hA5, 1'b1, 1'b1}));
    finish_frame();
    chk("A5 done idle", 32'(BUSY), 32'd0);

    // TX_DONE already high entering REQ is not a completion.
    do_reset();
    TX_DONE = 1;
    write1(8'hB6);
    tick(); tick();
    for (int i = 0; i < 3; i++) tick();
    chk("stale done ignored", 32'({TX_EN, TX_DATA}), 32'({1'b1, 8'hB6}));
    TX_DONE = 0; tick();
    chk("done fall keeps req", 32'(TX_EN), 32'd1);
    TX_DONE = 1; tick();
    chk("done rise completes", 32'({TX_EN, BUSY}), 32'({1'b0, 1'b1}));
    TX_DONE = 0; tick();
    chk("back idle", 32'(BUSY), 32'd0);

    // Overflow: 18 writes with transmitter stalled.
    do_reset();
    for (int i = 0; i < 18; i++) write1(8'h10 + 8'(i));
    chk("overflow state", 32'(obs()), 32'(pk(1, 8'h10, 1, 0, 16, 1, 1)));
    CLR_OVR = 1; tick(); CLR_OVR = 0;
    chk("clr_ovr", 32'(OVERRUN), 32'd0);
    WR_EN = 1; WR_DATA = 8'hEE; CLR_OVR = 1; tick();
    WR_EN = 0; CLR_OVR = 0;
    chk("set beats clear", 32'({OVERRUN, COUNT}), 32'({1'b1, 5'd16}));
    CLR_OVR = 1; tick(); CLR_OVR = 0;

    // Write while full in the LOAD cycle is accepted.
    finish_frame();
    tick();
    WR_EN = 1; WR_DATA = 8'h7E; tick(); WR_EN = 0;
    chk("full pop+write", 32'(obs()), 32'(pk(1, 8'h11, 1, 0, 16, 1, 0)));
    finish_frame();
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 8'h12 + 8'(i) : 8'h7E;
      wait_en($sformatf("drain%0d", i));
      chk($sformatf("drain%0d data", i), 32'(TX_DATA), 32'(e));
      finish_frame();
    end
    chk("drained", 32'({EMPTY, BUSY, COUNT}), 32'({1'b1, 1'b0, 5'd0}));

    // Async reset mid-REQ with 5 queued.
    do_reset();
    for (int i = 0; i < 6; i++) write1(8'h40 + 8'(i));
    chk("5 queued in req", 32'({TX_EN, COUNT}), 32'({1'b1, 5'd5}));
    #2 SCLR = 1;
    #1 chk("async reset", 32'({TX_EN, COUNT, EMPTY, BUSY}), 32'({1'b0, 5'd0, 1'b1, 1'b0}));
    SCLR = 0;
    tick();

    // Flush mid-REQ: current frame completes, nothing further.
    for (int i = 0; i < 6; i++) write1(8'h50 + 8'(i));
    FLUSH = 1; WR_EN = 1; WR_DATA = 8'h99; tick(); FLUSH = 0; WR_EN = 0;
    chk("flush in req", 32'(obs()), 32'(pk(1, 8'h50, 0, 1, 0, 1, 0)));
    finish_frame();
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= TX_EN; end
    chk("no tx after flush", 32'({seen, EMPTY}), 32'({1'b0, 1'b1}));

    // Flush during LOAD returns to idle with no request.
    write1(8'h66);
    tick();
    FLUSH = 1; tick(); FLUSH = 0;
    chk("flush in load", 32'({TX_EN, BUSY, EMPTY, COUNT}), 32'({1'b0, 1'b0, 1'b1, 5'd0}));
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= TX_EN; end
    chk("load flush no tx", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
